// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-path data sampler.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        SAMP_1   = 2'd0,
        SAMP_3   = 2'd1,
        SAMP_5   = 2'd2,
        SAMP_RSV = 2'd3
    } samp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_VOTE    = 2'd3
    } samp_state_e;

    localparam int unsigned DEFAULT_PRESCALE = 8;

    // Counter width able to hold 0..2*max_k+1 captured samples.
    function automatic int unsigned cnt_width(input int unsigned max_k);
        return $clog2(2 * max_k + 2);
    endfunction

endpackage

// File: rtl/samp_window.sv
// Sampling window geometry: midpoint, clamped half-window, bounds and sample count.
module samp_window
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned MAX_K      = 2,
    parameter int unsigned CNT_W      = 3
) (
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  samp_mode_e            cfg_mode,
    output logic                  win_ok_c,
    output logic [PRESCALE_W-1:0] k_c,
    output logic [PRESCALE_W-1:0] lo_c,
    output logic [PRESCALE_W-1:0] hi_c,
    output logic [CNT_W-1:0]      n_c
);

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] k_req;

    // k is clamped to mid so the window never reaches below tick 0.
    always_comb begin
        mid   = (cfg_prescale >> 1) - PRESCALE_W'(1);
        k_req = '0;
        case (cfg_mode)
            SAMP_3:  k_req = PRESCALE_W'(1);
            SAMP_5:  k_req = PRESCALE_W'(2);
            default: k_req = '0;
        endcase
        k_c = k_req;
        if (mid < k_c) k_c = mid;
        if (k_c > PRESCALE_W'(MAX_K)) k_c = PRESCALE_W'(MAX_K);
        lo_c     = mid - k_c;
        hi_c     = mid + k_c;
        n_c      = CNT_W'({k_c, 1'b1});
        win_ok_c = (cfg_prescale >= PRESCALE_W'(2));
    end

endmodule

// File: rtl/uart_rx_oversampler.sv
// Majority-vote RX data sampler over 1, 3 or 5 oversampled ticks centred on the bit midpoint.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned MAX_K      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [1:0]            samp_mode,
    input  logic                  RX_IN,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err
);

    localparam int unsigned CNT_W = cnt_width(MAX_K);

    samp_state_e           state_q, state_d;
    logic [PRESCALE_W-1:0] cfg_prescale_q;
    samp_mode_e            cfg_mode_q;
    logic [CNT_W-1:0]      ones_q, ones_d, capt_q, capt_d;
    logic                  bit_d, valid_d, noise_d;

    logic                  cfg_load;
    logic [PRESCALE_W-1:0] eff_prescale;
    samp_mode_e            eff_mode;
    logic                  win_ok_c;
    logic [PRESCALE_W-1:0] k_c, lo_c, hi_c;
    logic [CNT_W-1:0]      n_c;

    logic                  clr, in_win;
    logic [CNT_W-1:0]      ones_base, capt_base, ones_sum, capt_sum;

    // A bit-start tick uses the incoming config so a change there applies to this bit.
    always_comb begin
        cfg_load     = data_samp_en && (edge_cnt == '0);
        eff_prescale = cfg_load ? Prescale : cfg_prescale_q;
        eff_mode     = cfg_load ? samp_mode_e'(samp_mode) : cfg_mode_q;
    end

    samp_window #(
        .PRESCALE_W (PRESCALE_W),
        .MAX_K      (MAX_K),
        .CNT_W      (CNT_W)
    ) u_samp_window (
        .cfg_prescale (eff_prescale),
        .cfg_mode     (eff_mode),
        .win_ok_c     (win_ok_c),
        .k_c          (k_c),
        .lo_c         (lo_c),
        .hi_c         (hi_c),
        .n_c          (n_c)
    );

    // Next state, accumulator update and vote.
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        capt_d    = capt_q;
        bit_d     = sampled_bit;
        valid_d   = 1'b0;
        noise_d   = 1'b0;
        clr       = (edge_cnt == '0) || (state_q == ST_IDLE);
        in_win    = win_ok_c && (edge_cnt >= lo_c) && (edge_cnt <= hi_c);
        ones_base = clr ? '0 : ones_q;
        capt_base = clr ? '0 : capt_q;
        ones_sum  = ones_base + CNT_W'(RX_IN);
        capt_sum  = capt_base + CNT_W'(1);

        if (!data_samp_en) begin
            state_d = ST_IDLE;
            ones_d  = '0;
            capt_d  = '0;
            bit_d   = 1'b0;
        end else begin
            ones_d = ones_base;
            capt_d = capt_base;
            if (in_win) begin
                ones_d = ones_sum;
                capt_d = capt_sum;
                if (edge_cnt == hi_c) begin
                    state_d = ST_VOTE;
                    // A window shortened by skipped ticks gives no strobe.
                    if (capt_sum == n_c) begin
                        valid_d = 1'b1;
                        bit_d   = (ones_sum > CNT_W'(k_c));
                        noise_d = (ones_sum != '0) && (ones_sum != n_c);
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end else begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cfg_prescale_q <= PRESCALE_W'(DEFAULT_PRESCALE);
            cfg_mode_q     <= SAMP_3;
            ones_q         <= '0;
            capt_q         <= '0;
            sampled_bit    <= 1'b0;
            sample_valid   <= 1'b0;
            noise_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            capt_q       <= capt_d;
            sampled_bit  <= bit_d;
            sample_valid <= valid_d;
            noise_err    <= noise_d;
            if (cfg_load) begin
                cfg_prescale_q <= Prescale;
                cfg_mode_q     <= samp_mode_e'(samp_mode);
            end
        end
    end

endmodule
